// File: rtl/lpm_abs_pkg.sv
// Shared definitions for the lpm_abs scheduler: result-register FSM encodings
// and the width of the optional overflow statistics counter.
package lpm_abs_pkg;

    // Result register occupancy: EMPTY drives res_valid=0, FULL drives res_valid=1.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Width of the saturating overflow counter.
    localparam int unsigned STATS_W = 16;

endpackage : lpm_abs_pkg

// File: rtl/lpm_abs.sv
// Combinational two's-complement absolute value with most-negative detection.
module lpm_abs #(
    parameter int lpm_width = 8
) (
    input  logic [lpm_width-1:0] data,
    output logic [lpm_width-1:0] result,
    output logic                 overflow
);

    // The most-negative value has no positive counterpart; negation wraps
    // back to itself, which is exactly the required result.
    assign overflow = data[lpm_width-1] & ~(|data[lpm_width-2:0]);
    assign result   = data[lpm_width-1] ? (~data + lpm_width'(1)) : data;

endmodule : lpm_abs

// File: rtl/lpm_abs_sched.sv
// Round-robin arbiter feeding one shared abs datapath with a single-entry
// result register (EMPTY/FULL). Optional macro LPM_ABS_SCHED_STATS_EN adds
// the ovf_count output, a saturating count of accepted overflow operands.
module lpm_abs_sched
    import lpm_abs_pkg::*;
#(
    parameter int lpm_width = 8,
    parameter int lpm_reqs  = 4,
    parameter     lpm_hint  = "UNUSED"
) (
    input  logic                          clock,
    input  logic                          aclr_n,
    input  logic [lpm_reqs-1:0]           req_valid,
    input  logic [lpm_reqs*lpm_width-1:0] req_data,
    output logic [lpm_reqs-1:0]           req_ready,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [lpm_width-1:0]          result,
    output logic                          overflow,
    output logic [$clog2(lpm_reqs)-1:0]   res_id
`ifdef LPM_ABS_SCHED_STATS_EN
    ,
    output logic [STATS_W-1:0]            ovf_count
`endif
);

    localparam int ID_W = $clog2(lpm_reqs);

    state_e               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [lpm_width-1:0] result_q;
    logic                 overflow_q;
    logic [ID_W-1:0]      res_id_q;

    logic                 grant_any;
    logic [ID_W-1:0]      grant_idx;
    logic                 can_accept;
    logic                 xfer;
    logic [lpm_width-1:0] sel_data;
    logic [lpm_width-1:0] abs_result;
    logic                 abs_overflow;

    // The hint is a pure tool annotation; it is only touched at elaboration.
    if (lpm_hint == "") begin : g_hint_empty
    end

    // Round-robin search: first valid requester at or after rr_ptr_q.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_any = 1'b0;
        grant_idx = '0;
        // Scan from the far end so the nearest candidate to the pointer is the last writer.
        for (int k = lpm_reqs - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr_q) + k) % lpm_reqs]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'((int'(rr_ptr_q) + k) % lpm_reqs);
            end
        end
    end

    // A grant is only offered when the result slot is free or being drained,
    // and never while reset is held.
    assign can_accept = (state_q == ST_EMPTY) || res_ready;
    assign xfer       = grant_any && can_accept && aclr_n;

    // One-hot grant to the winner when a transfer can happen this cycle.
    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_data = req_data[int'(grant_idx) * lpm_width +: lpm_width];

    lpm_abs #(
        .lpm_width (lpm_width)
    ) u_abs (
        .data     (sel_data),
        .result   (abs_result),
        .overflow (abs_overflow)
    );

    // Pointer moves past the winner on a transfer, otherwise holds.
    assign rr_ptr_d = xfer ? ID_W'((int'(grant_idx) + 1) % lpm_reqs) : rr_ptr_q;

    // State register.
    always_ff @(posedge clock or negedge aclr_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!aclr_n) begin
            state_q  <= ST_EMPTY;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next-state: fill on transfer, drain on res_ready without a reload.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (xfer)                   state_d = ST_FULL;
            ST_FULL:  if (res_ready && !xfer)     state_d = ST_EMPTY;
            default:                              state_d = ST_EMPTY;
        endcase
    end

    // Result register loads only on a transfer, so it holds while stalled.
    always_ff @(posedge clock or negedge aclr_n) begin
        // NOTE: the result payload is reset too, because zero outputs during reset are part of the interface.
        if (!aclr_n) begin
            result_q   <= '0;
            overflow_q <= 1'b0;
            res_id_q   <= '0;
        end else if (xfer) begin
            result_q   <= abs_result;
            overflow_q <= abs_overflow;
            res_id_q   <= grant_idx;
        end
    end

    // Output decode from the FSM state and result register.
    always_comb begin
        res_valid = (state_q == ST_FULL);
        result    = result_q;
        overflow  = overflow_q;
        res_id    = res_id_q;
    end

`ifdef LPM_ABS_SCHED_STATS_EN
    logic [STATS_W-1:0] ovf_q;

    // Saturating count of overflow operands accepted into the result register.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            ovf_q <= '0;
        end else if (xfer && abs_overflow && (ovf_q != '1)) begin
            ovf_q <= ovf_q + STATS_W'(1);
        end
    end

    assign ovf_count = ovf_q;
`endif

endmodule : lpm_abs_sched
